// File: rtl/ah_cam_pkg.sv
// rtl/ah_cam_pkg.sv - shared AH CAM types, defaults and width helper
package ah_cam_pkg;

    localparam int AH_CAM_DEPTH = 10;
    localparam int AH_CAM_DW    = 16;
    localparam int AH_CAM_KW    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lk_state_e;

    // Width needed to hold 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ah_cam_requester_if.sv
// rtl/ah_cam_requester_if.sv - write, snoop and result signals of the AH CAM requester
interface ah_cam_requester_if
    import ah_cam_pkg::*;
#(
    parameter int DW = AH_CAM_DW,
    parameter int KW = AH_CAM_KW,
    parameter int CW = credit_w(AH_CAM_DEPTH)
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] cam_wdata;
    logic          cam_wvalid;
    logic          cam_wcredit;
    logic [KW-1:0] lk_key;
    logic          lk_valid;
    logic          lk_ready;
    logic [KW-1:0] cam_sin;
    logic          cam_svalid;
    logic          cam_srsp_valid;
    logic          cam_smatch;
    logic [DW-1:0] cam_sdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_match;
    logic [DW-1:0] rsp_data;
    logic          rsp_timeout;
    logic [CW-1:0] credit_cnt;
    logic          err;

    modport master (
        input  in_data, in_valid, cam_wcredit, lk_key, lk_valid,
               cam_srsp_valid, cam_smatch, cam_sdata, rsp_ready,
        output in_ready, cam_wdata, cam_wvalid, lk_ready, cam_sin, cam_svalid,
               rsp_valid, rsp_match, rsp_data, rsp_timeout, credit_cnt, err
    );

    modport slave (
        output in_data, in_valid, cam_wcredit, lk_key, lk_valid,
               cam_srsp_valid, cam_smatch, cam_sdata, rsp_ready,
        input  in_ready, cam_wdata, cam_wvalid, lk_ready, cam_sin, cam_svalid,
               rsp_valid, rsp_match, rsp_data, rsp_timeout, credit_cnt, err
    );

endinterface

// File: rtl/ah_cam_credit_ctr.sv
// rtl/ah_cam_credit_ctr.sv - CAM write credit counter with saturation and sticky overflow error
module ah_cam_credit_ctr #(
    parameter int DEPTH = 10,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_an,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          ovf_err
);

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            cnt     <= CW'(DEPTH);
            ovf_err <= 1'b0;
        end else begin
            unique case ({dec, inc})
                2'b10: cnt <= cnt - CW'(1);
                2'b01: begin
                    // A credit beyond the CAM depth means the CAM returned one we never spent.
                    if (cnt == CW'(DEPTH)) begin
                        ovf_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ah_cam_requester.sv
// rtl/ah_cam_requester.sv - AH CAM requester; optional snoop timeout under AH_CAM_REQ_TIMEOUT_EN
module ah_cam_requester
    import ah_cam_pkg::*;
#(
    parameter int DEPTH   = AH_CAM_DEPTH,
    parameter int DW      = AH_CAM_DW,
    parameter int KW      = AH_CAM_KW,
    parameter int TMO_CYC = 64
) (
    input logic               clk,
    input logic               rst_an,
    ah_cam_requester_if.master bus
);

    localparam int CW = credit_w(DEPTH);

    logic [CW-1:0] credit_q;
    logic          ovf_err;
    logic          wfire;
    logic [DW-1:0] wdata_q;
    logic          wvalid_q;

    lk_state_e     state_q, state_d;
    logic [KW-1:0] key_q;
    logic          rsp_match_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_tmo_q;
    logic          proto_err_q;
    logic          key_cap, rsp_cap, tmo_take, proto_set;
    logic          lk_ready_c, svalid_c, rsp_valid_c;
    logic          tmo_hit;

    assign bus.in_ready = (credit_q != '0);
    assign wfire        = bus.in_valid & bus.in_ready;

    ah_cam_credit_ctr #(.DEPTH(DEPTH), .CW(CW)) u_credit (
        .clk     (clk),
        .rst_an  (rst_an),
        .dec     (wfire),
        .inc     (bus.cam_wcredit),
        .cnt     (credit_q),
        .ovf_err (ovf_err)
    );

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
        end else begin
            wvalid_q <= wfire;
            if (wfire) wdata_q <= bus.in_data;
        end
    end

`ifdef AH_CAM_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // REQ always precedes WAIT, so clearing there resets the count on WAIT entry.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            tmo_cnt <= '0;
        end else if (state_q == REQ) begin
            tmo_cnt <= '0;
        end else if (state_q == WAIT) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit = (state_q == WAIT) && (tmo_cnt == TW'(TMO_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_CYC > 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        lk_ready_c  = 1'b0;
        svalid_c    = 1'b0;
        rsp_valid_c = 1'b0;
        key_cap     = 1'b0;
        rsp_cap     = 1'b0;
        tmo_take    = 1'b0;
        proto_set   = 1'b0;
        unique case (state_q)
            IDLE: begin
                lk_ready_c = 1'b1;
                if (bus.lk_valid) begin
                    key_cap = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                svalid_c = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // A response landing on the timeout cycle still wins.
                if (bus.cam_srsp_valid) begin
                    rsp_cap = 1'b1;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    tmo_take = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.cam_srsp_valid && (state_q != WAIT)) proto_set = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            key_q       <= '0;
            rsp_match_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tmo_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (key_cap) key_q <= bus.lk_key;
            if (rsp_cap) begin
                rsp_match_q <= bus.cam_smatch;
                rsp_data_q  <= bus.cam_smatch ? bus.cam_sdata : '0;
                rsp_tmo_q   <= 1'b0;
            end else if (tmo_take) begin
                rsp_match_q <= 1'b0;
                rsp_data_q  <= '0;
                rsp_tmo_q   <= 1'b1;
            end
            if (proto_set) proto_err_q <= 1'b1;
        end
    end

    assign bus.cam_wdata   = wdata_q;
    assign bus.cam_wvalid  = wvalid_q;
    assign bus.lk_ready    = lk_ready_c;
    assign bus.cam_sin     = key_q;
    assign bus.cam_svalid  = svalid_c;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_match   = rsp_match_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_timeout = rsp_tmo_q;
    assign bus.credit_cnt  = credit_q;
    assign bus.err         = ovf_err | proto_err_q;

endmodule

// File: tb/tb_ah_cam_requester.sv
// tb/tb_ah_cam_requester.sv - directed bench for ah_cam_requester
module tb_ah_cam_requester;

    logic clk = 1'b0;
    logic rst_an = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    ah_cam_requester_if #(.DW(16), .KW(8), .CW(4)) bus ();

    ah_cam_requester #(.DEPTH(10), .DW(16), .KW(8), .TMO_CYC(8)) dut (
        .clk    (clk),
        .rst_an (rst_an),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.in_data        = '0;
        bus.in_valid       = 1'b0;
        bus.cam_wcredit    = 1'b0;
        bus.lk_key         = '0;
        bus.lk_valid       = 1'b0;
        bus.cam_srsp_valid = 1'b0;
        bus.cam_smatch     = 1'b0;
        bus.cam_sdata      = '0;
        bus.rsp_ready      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_an = 1'b0;
        step();
        step();
        rst_an = 1'b1;
        step();
    endtask

    task automatic do_lookup(input logic [7:0] key);
        bus.lk_key   = key;
        bus.lk_valid = 1'b1;
        check("lk_ready_idle", 32'(bus.lk_ready), 32'd1);
        step();
        bus.lk_valid = 1'b0;
        check("svalid_req", 32'(bus.cam_svalid), 32'd1);
        check("sin_req", 32'(bus.cam_sin), 32'(key));
        step();
        check("svalid_wait", 32'(bus.cam_svalid), 32'd0);
    endtask

    initial begin
        int pulses;

        // Reset state
        do_reset();
        check("rst_credit", 32'(bus.credit_cnt), 32'd10);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_lk_ready", 32'(bus.lk_ready), 32'd1);
        check("rst_wvalid", 32'(bus.cam_wvalid), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_svalid", 32'(bus.cam_svalid), 32'd0);
        check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);

        // Twelve offered entries, only ten credits
        pulses = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.in_data = 16'h1000 + 16'(i);
            if (i == 12) bus.in_valid = 1'b0;
            step();
            if (bus.cam_wvalid) begin
                check("wdata_seq", 32'(bus.cam_wdata), 32'h1000 + 32'(pulses));
                pulses++;
            end
        end
        check("wvalid_pulses", 32'(pulses), 32'd10);
        check("credit_empty", 32'(bus.credit_cnt), 32'd0);
        check("in_ready_empty", 32'(bus.in_ready), 32'd0);

        // One credit back re-enables exactly one write
        bus.cam_wcredit = 1'b1;
        step();
        bus.cam_wcredit = 1'b0;
        check("in_ready_after_credit", 32'(bus.in_ready), 32'd1);
        check("credit_one", 32'(bus.credit_cnt), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hBEEF;
        step();
        bus.in_valid = 1'b0;
        check("wvalid_refill", 32'(bus.cam_wvalid), 32'd1);
        check("wdata_refill", 32'(bus.cam_wdata), 32'hBEEF);
        check("credit_zero_again", 32'(bus.credit_cnt), 32'd0);
        check("in_ready_zero_again", 32'(bus.in_ready), 32'd0);
        step();
        check("wvalid_drop", 32'(bus.cam_wvalid), 32'd0);
        check("wdata_hold", 32'(bus.cam_wdata), 32'hBEEF);

        // Simultaneous write and credit at 5
        bus.cam_wcredit = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("credit_five", 32'(bus.credit_cnt), 32'd5);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5555;
        step();
        bus.in_valid = 1'b0;
        check("credit_same_cycle", 32'(bus.credit_cnt), 32'd5);
        check("wvalid_same_cycle", 32'(bus.cam_wvalid), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("credit_full", 32'(bus.credit_cnt), 32'd10);
        check("err_before_ovf", 32'(bus.err), 32'd0);
        step();
        bus.cam_wcredit = 1'b0;
        check("credit_saturate", 32'(bus.credit_cnt), 32'd10);
        check("err_ovf", 32'(bus.err), 32'd1);
        step();
        check("err_sticky", 32'(bus.err), 32'd1);

        do_reset();
        check("err_cleared_by_reset", 32'(bus.err), 32'd0);

        // Lookup hit with one-cycle CAM response
        do_lookup(8'h3C);
        bus.cam_srsp_valid = 1'b1;
        bus.cam_smatch     = 1'b1;
        bus.cam_sdata      = 16'hA53C;
        step();
        bus.cam_srsp_valid = 1'b0;
        bus.cam_sdata      = 16'h0000;
        check("hit_rsp_valid_c3", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("hit_match", 32'(bus.rsp_match), 32'd1);
            check("hit_data", 32'(bus.rsp_data), 32'hA53C);
            check("hit_timeout", 32'(bus.rsp_timeout), 32'd0);
            check("hit_lk_ready", 32'(bus.lk_ready), 32'd0);
            check("hit_hold_valid", 32'(bus.rsp_valid), 32'd1);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("hit_release_valid", 32'(bus.rsp_valid), 32'd0);
        check("hit_release_lk_ready", 32'(bus.lk_ready), 32'd1);
        check("hit_err", 32'(bus.err), 32'd0);

`ifdef AH_CAM_REQ_TIMEOUT_EN
        // No response: timeout after eight WAIT cycles
        do_lookup(8'h22);
        for (int i = 0; i < 7; i++) step();
        check("tmo_not_yet", 32'(bus.rsp_valid), 32'd0);
        step();
        check("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("tmo_flag", 32'(bus.rsp_timeout), 32'd1);
        check("tmo_match", 32'(bus.rsp_match), 32'd0);
        check("tmo_data", 32'(bus.rsp_data), 32'd0);
        check("tmo_err_clean", 32'(bus.err), 32'd0);
        bus.cam_srsp_valid = 1'b1;
        bus.cam_smatch     = 1'b1;
        bus.cam_sdata      = 16'h7777;
        step();
        bus.cam_srsp_valid = 1'b0;
        check("late_err", 32'(bus.err), 32'd1);
        check("late_data_kept", 32'(bus.rsp_data), 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("tmo_release", 32'(bus.lk_ready), 32'd1);
        do_reset();
`else
        // Without the timeout a lookup waits for its response indefinitely
        do_lookup(8'h11);
        for (int i = 0; i < 20; i++) step();
        check("wait_persist", 32'(bus.rsp_valid), 32'd0);
        bus.cam_srsp_valid = 1'b1;
        bus.cam_smatch     = 1'b1;
        bus.cam_sdata      = 16'h1111;
        step();
        bus.cam_srsp_valid = 1'b0;
        check("slow_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("slow_rsp_data", 32'(bus.rsp_data), 32'h1111);
        check("slow_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
`endif

        // Lookup miss: data forced to zero
        do_lookup(8'h5A);
        bus.cam_srsp_valid = 1'b1;
        bus.cam_smatch     = 1'b0;
        bus.cam_sdata      = 16'hFFFF;
        step();
        bus.cam_srsp_valid = 1'b0;
        check("miss_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("miss_match", 32'(bus.rsp_match), 32'd0);
        check("miss_data", 32'(bus.rsp_data), 32'd0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("miss_err_clean", 32'(bus.err), 32'd0);

        // Unsolicited response while idle
        bus.cam_srsp_valid = 1'b1;
        bus.cam_smatch     = 1'b1;
        bus.cam_sdata      = 16'h1234;
        step();
        bus.cam_srsp_valid = 1'b0;
        check("unsol_err", 32'(bus.err), 32'd1);
        check("unsol_lk_ready", 32'(bus.lk_ready), 32'd1);
        check("unsol_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("unsol_svalid", 32'(bus.cam_svalid), 32'd0);
        check("unsol_data_kept", 32'(bus.rsp_data), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
